// File: rtl/vwrite_axi_burst_if.sv
// Bundle of databus-side and AXI4 write-side signals for the databus-to-AXI write bridge.
// The bridge takes the master view; the environment (databus source + AXI slave) takes the slave view.
interface vwrite_axi_burst_if #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int LEN_W      = 16
);
   logic                    databus_valid_i;
   logic                    databus_ready_o;
   logic [AXI_ADDR_W-1:0]   databus_addr_i;
   logic [LEN_W-1:0]        databus_len_i;
   logic [AXI_DATA_W-1:0]   databus_wdata_i;
   logic [AXI_DATA_W/8-1:0] databus_wstrb_i;
   logic                    databus_last_o;

   logic                    m_awvalid_o;
   logic                    m_awready_i;
   logic [AXI_ADDR_W-1:0]   m_awaddr_o;
   logic [7:0]              m_awlen_o;
   logic [2:0]              m_awsize_o;
   logic [1:0]              m_awburst_o;

   logic                    m_wvalid_o;
   logic                    m_wready_i;
   logic [AXI_DATA_W-1:0]   m_wdata_o;
   logic [AXI_DATA_W/8-1:0] m_wstrb_o;
   logic                    m_wlast_o;

   logic                    m_bvalid_i;
   logic                    m_bready_o;
   logic [1:0]              m_bresp_i;

   modport master (
      input  databus_valid_i, databus_addr_i, databus_len_i, databus_wdata_i, databus_wstrb_i,
      output databus_ready_o, databus_last_o,
      output m_awvalid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o,
      input  m_awready_i,
      output m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o,
      input  m_wready_i,
      input  m_bvalid_i, m_bresp_i,
      output m_bready_o
   );

   modport slave (
      output databus_valid_i, databus_addr_i, databus_len_i, databus_wdata_i, databus_wstrb_i,
      input  databus_ready_o, databus_last_o,
      input  m_awvalid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o,
      output m_awready_i,
      input  m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o,
      output m_wready_i,
      output m_bvalid_i, m_bresp_i,
      input  m_bready_o
   );
endinterface

// File: rtl/vwrite_axi_burst.sv
// Databus write transfer to AXI4 INCR bursts, split at 256 beats and 4 KB pages.
// Holds off the next transfer until every B response of the current one has returned.
module vwrite_axi_burst #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int LEN_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   vwrite_axi_burst_if.master bus,
   output logic               busy_o,
   output logic               error_o
);
   localparam int BYTES = AXI_DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CMP_W = (LEN_W > 13) ? LEN_W : 13;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                state_q, state_d;
   logic [AXI_ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]      beats_left_q, beats_left_d;
   logic [LEN_W-1:0]      outstanding_q, outstanding_d;
   logic [8:0]            beat_cnt_q, beat_cnt_d;
   logic [8:0]            burst_q, burst_d;
   logic                  error_q, error_d;

   logic [LEN_W:0]        len_round;
   logic [LEN_W-1:0]      beats_init;
   logic [12:0]           room_bytes;
   logic [CMP_W-1:0]      room_beats, left_beats, min_beats;
   logic [8:0]            burst;
   logic                  beat, burst_end, b_hs;

   // Burst size for the current position: remaining beats, 4 KB page room, 256-beat cap.
   always_comb begin
      len_round  = {1'b0, bus.databus_len_i} + (LEN_W+1)'(BYTES - 1);
      beats_init = LEN_W'(len_round >> OFF_W);
      room_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};
      room_beats = CMP_W'(room_bytes >> OFF_W);
      left_beats = CMP_W'(beats_left_q);
      min_beats  = (left_beats < room_beats) ? left_beats : room_beats;
      burst      = (min_beats > CMP_W'(256)) ? 9'd256 : min_beats[8:0];
   end

   assign beat      = (state_q == DATA) & bus.databus_valid_i & bus.m_wready_i;
   assign burst_end = beat & (beat_cnt_q == 9'd1);
   assign b_hs      = bus.m_bvalid_i & ~rst;

   // A burst completing and a response arriving in the same cycle cancel out.
   always_comb begin
      outstanding_d = outstanding_q;
      if (burst_end && !b_hs) begin
         outstanding_d = outstanding_q + LEN_W'(1);
      end else if (!burst_end && b_hs && outstanding_q != '0) begin
         outstanding_d = outstanding_q - LEN_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      beat_cnt_d   = beat_cnt_q;
      burst_d      = burst_q;
      error_d      = error_q;
      case (state_q)
         IDLE: begin
            if (bus.databus_valid_i && bus.databus_len_i != '0) begin
               cur_addr_d   = bus.databus_addr_i & ~AXI_ADDR_W'(BYTES - 1);
               beats_left_d = beats_init;
               error_d      = 1'b0;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (bus.m_awready_i) begin
               burst_d    = burst;
               beat_cnt_d = burst;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               beat_cnt_d   = beat_cnt_q - 9'd1;
               beats_left_d = beats_left_q - LEN_W'(1);
               if (burst_end) begin
                  cur_addr_d = cur_addr_q + (AXI_ADDR_W'(burst_q) << OFF_W);
                  state_d    = (beats_left_q > LEN_W'(1)) ? ADDR : RESP;
               end
            end
         end
         RESP: begin
            if (outstanding_d == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (b_hs && bus.m_bresp_i != 2'b00) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cur_addr_q    <= '0;
         beats_left_q  <= '0;
         outstanding_q <= '0;
         beat_cnt_q    <= '0;
         burst_q       <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         beats_left_q  <= beats_left_d;
         outstanding_q <= outstanding_d;
         beat_cnt_q    <= beat_cnt_d;
         burst_q       <= burst_d;
         error_q       <= error_d;
      end
   end

   assign bus.m_awvalid_o     = (state_q == ADDR);
   assign bus.m_awaddr_o      = cur_addr_q;
   assign bus.m_awlen_o       = (state_q == ADDR) ? 8'(burst - 9'd1) : 8'd0;
   assign bus.m_awsize_o      = 3'(OFF_W);
   assign bus.m_awburst_o     = 2'b01;

   // W channel is a straight pass-through of the databus while a burst is open.
   assign bus.m_wvalid_o      = (state_q == DATA) & bus.databus_valid_i;
   assign bus.databus_ready_o = (state_q == DATA) & bus.m_wready_i;
   assign bus.m_wdata_o       = bus.databus_wdata_i;
   assign bus.m_wstrb_o       = bus.databus_wstrb_i;
   assign bus.m_wlast_o       = (state_q == DATA) & (beat_cnt_q == 9'd1);
   assign bus.databus_last_o  = beat & (beats_left_q == LEN_W'(1));

   assign bus.m_bready_o      = ~rst;
   assign busy_o              = (state_q != IDLE);
   assign error_o             = error_q;
endmodule

// File: tb/tb_vwrite_axi_burst.sv
// Directed bench for vwrite_axi_burst: scripted databus source, reactive AXI slave, handshake logs.
module tb_vwrite_axi_burst;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, error;

   vwrite_axi_burst_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(16)) bus ();

   vwrite_axi_burst #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy_o  (busy),
      .error_o (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // slave knobs and state
   bit aw_rand = 0, w_rand = 0, b_rand = 0, b_err_first = 0;
   int b_delay = 0, b_min = 1;
   int b_pending = 0, b_timer = 0, b_idx = 0, slave_bursts = 0;

   // handshake logs
   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [31:0] w_data_q[$];
   logic [3:0]  w_strb_q[$];
   bit          w_last_q[$];
   bit          d_last_q[$];
   int aw_hs = 0, wl_cnt = 0, b_cnt = 0, peak = 0, proto_err = 0;
   int last_b_cyc = -1, busy_fall_cyc = -1;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // AXI slave: observe at negedge, drive just after the next posedge
   initial begin
      bus.m_awready_i = 1'b0;
      bus.m_wready_i  = 1'b0;
      bus.m_bvalid_i  = 1'b0;
      bus.m_bresp_i   = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            b_pending = 0; b_timer = 0; b_idx = 0; slave_bursts = 0;
         end else begin
            if (bus.m_wvalid_o && bus.m_wready_i && bus.m_wlast_o) begin
               b_pending++;
               slave_bursts++;
            end
            if (bus.m_bvalid_i && bus.m_bready_o) begin
               b_pending--;
               b_idx++;
               b_timer = 0;
            end
         end
         @(posedge clk);
         #1;
         bus.m_awready_i = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.m_wready_i  = w_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.m_bvalid_i  = 1'b0;
         bus.m_bresp_i   = 2'b00;
         if (!rst && b_pending > 0 && slave_bursts >= b_min) begin
            if (b_timer >= b_delay && (!b_rand || $urandom_range(0, 1) == 1)) begin
               bus.m_bvalid_i = 1'b1;
               bus.m_bresp_i  = (b_err_first && b_idx == 0) ? 2'b10 : 2'b00;
            end else begin
               b_timer++;
            end
         end
      end
   end

   // Monitor: logs handshakes and counts protocol violations
   initial begin
      bit          awv_prev, busy_prev;
      logic [31:0] prev_addr;
      logic [7:0]  prev_len;
      awv_prev = 0; busy_prev = 0; prev_addr = '0; prev_len = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_hs = 0; wl_cnt = 0; b_cnt = 0; awv_prev = 0; busy_prev = 0;
         end else begin
            if (awv_prev && (!bus.m_awvalid_o || bus.m_awaddr_o !== prev_addr || bus.m_awlen_o !== prev_len))
               proto_err++;
            if (bus.m_wvalid_o && aw_hs == wl_cnt) proto_err++;
            if (bus.databus_last_o && !(bus.databus_valid_i && bus.databus_ready_o)) proto_err++;
            if (bus.m_awvalid_o && bus.m_awready_i) begin
               aw_addr_q.push_back(bus.m_awaddr_o);
               aw_len_q.push_back(bus.m_awlen_o);
               aw_hs++;
            end
            if (bus.m_wvalid_o && bus.m_wready_i) begin
               w_data_q.push_back(bus.m_wdata_o);
               w_strb_q.push_back(bus.m_wstrb_o);
               w_last_q.push_back(bus.m_wlast_o);
               d_last_q.push_back(bus.databus_last_o);
               if (bus.m_wlast_o) wl_cnt++;
            end
            if (bus.m_bvalid_i && bus.m_bready_o) begin
               b_cnt++;
               last_b_cyc = cyc;
            end
            if (wl_cnt - b_cnt > peak) peak = wl_cnt - b_cnt;
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            awv_prev  = bus.m_awvalid_o && !bus.m_awready_i;
            prev_addr = bus.m_awaddr_o;
            prev_len  = bus.m_awlen_o;
            busy_prev = busy;
         end
      end
   end

   task automatic clear_logs();
      aw_addr_q.delete(); aw_len_q.delete();
      w_data_q.delete(); w_strb_q.delete(); w_last_q.delete(); d_last_q.delete();
      aw_hs = 0; wl_cnt = 0; b_cnt = 0; peak = 0; proto_err = 0;
      last_b_cyc = -1; busy_fall_cyc = -1;
      b_idx = 0; slave_bursts = 0; b_timer = 0;
   endtask

   task automatic set_knobs(input bit ar, input bit wr, input bit br, input int bd, input int bm, input bit be);
      aw_rand = ar; w_rand = wr; b_rand = br; b_delay = bd; b_min = bm; b_err_first = be;
   endtask

   // Runs one databus transfer; words are base+i, last word carries last_strb.
   task automatic run_xfer(input logic [31:0] addr, input logic [15:0] len, input int nwords,
                           input logic [31:0] base, input logic [3:0] last_strb, input bit vrand);
      int i = 0;
      int guard = 0;
      clear_logs();
      bus.databus_addr_i = addr;
      bus.databus_len_i  = len;
      while (i < nwords && guard < 20000) begin
         if (vrand && $urandom_range(0, 3) == 0) begin
            bus.databus_valid_i = 1'b0;
         end else begin
            bus.databus_valid_i = 1'b1;
            bus.databus_wdata_i = base + 32'(i);
            bus.databus_wstrb_i = (i == nwords - 1) ? last_strb : 4'hF;
         end
         @(negedge clk);
         if (bus.databus_valid_i && bus.databus_ready_o) i++;
         @(posedge clk);
         #1;
         guard++;
      end
      bus.databus_valid_i = 1'b0;
      total++;
      if (i !== nwords) begin
         bad++;
         $display("FAIL words_accepted addr=%h got=%0d want=%0d", addr, i, nwords);
      end
      guard = 0;
      while (guard < 2000) begin
         @(negedge clk);
         if (!busy) break;
         guard++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout addr=%h busy=%b want=0", addr, busy);
      end
      $display("xfer addr=%h len=%0d aw=%0d beats=%0d bresp=%0d err=%b",
               addr, len, aw_addr_q.size(), w_data_q.size(), b_cnt, error);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] ctl;
      rst = 1'b1;
      bus.databus_valid_i = 1'b0; bus.databus_addr_i = '0; bus.databus_len_i = '0;
      bus.databus_wdata_i = '0;   bus.databus_wstrb_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ctl = {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_wlast_o, bus.databus_ready_o,
             bus.databus_last_o, bus.m_bready_o, busy, error};
      total++;
      if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%b want=00000000", ctl); end
      total++;
      if (bus.m_awaddr_o !== 32'h0 || bus.m_awlen_o !== 8'h0) begin
         bad++; $display("FAIL reset_aw got=%h/%h want=0/0", bus.m_awaddr_o, bus.m_awlen_o);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.m_bready_o !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL post_reset bready=%b busy=%b want=1/0", bus.m_bready_o, busy);
      end
      total++;
      if (bus.m_awsize_o !== 3'd2 || bus.m_awburst_o !== 2'b01) begin
         bad++; $display("FAIL aw_consts got=%0d/%b want=2/01", bus.m_awsize_o, bus.m_awburst_o);
      end
      $display("reset checked");
      @(posedge clk); #1;
   endtask

   task automatic test_single_burst();
      logic [3:0] wl, dl;
      set_knobs(0, 0, 0, 0, 1, 0);
      run_xfer(32'h100, 16'd16, 4, 32'hA000_0000, 4'hF, 1'b0);
      wl = '0; dl = '0;
      foreach (w_last_q[k]) if (k < 4) begin wl[k] = w_last_q[k]; dl[k] = d_last_q[k]; end
      total++;
      if (aw_addr_q.size() !== 1 || aw_addr_q[0] !== 32'h100 || aw_len_q[0] !== 8'd3) begin
         bad++; $display("FAIL single_aw n=%0d addr=%h len=%0d want=1/100/3", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]);
      end
      total++;
      if (w_data_q.size() !== 4 || w_data_q[0] !== 32'hA000_0000 || w_data_q[3] !== 32'hA000_0003) begin
         bad++; $display("FAIL single_data n=%0d d0=%h d3=%h want=4/a0000000/a0000003", w_data_q.size(), w_data_q[0], w_data_q[3]);
      end
      total++;
      if (wl !== 4'b1000 || dl !== 4'b1000) begin
         bad++; $display("FAIL single_last wlast=%b dlast=%b want=1000/1000", wl, dl);
      end
      total++;
      if (busy_fall_cyc !== last_b_cyc + 1) begin
         bad++; $display("FAIL single_busy_fall got=%0d want=%0d", busy_fall_cyc, last_b_cyc + 1);
      end
      total++;
      if (proto_err !== 0 || error !== 1'b0) begin
         bad++; $display("FAIL single_proto proto=%0d err=%b want=0/0", proto_err, error);
      end
   endtask

   task automatic test_4k_split();
      logic [3:0] wl, dl;
      set_knobs(0, 0, 0, 0, 1, 0);
      run_xfer(32'hFF8, 16'd16, 4, 32'hB000_0000, 4'hF, 1'b0);
      wl = '0; dl = '0;
      foreach (w_last_q[k]) if (k < 4) begin wl[k] = w_last_q[k]; dl[k] = d_last_q[k]; end
      total++;
      if (aw_addr_q.size() !== 2 || aw_addr_q[0] !== 32'hFF8 || aw_len_q[0] !== 8'd1 ||
          aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd1) begin
         bad++; $display("FAIL split4k_aw n=%0d a0=%h l0=%0d a1=%h l1=%0d want=2/ff8/1/1000/1",
                         aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
      total++;
      if (wl !== 4'b1010 || dl !== 4'b1000) begin
         bad++; $display("FAIL split4k_last wlast=%b dlast=%b want=1010/1000", wl, dl);
      end
   endtask

   task automatic test_256_split();
      int errs = 0;
      set_knobs(0, 0, 0, 20, 2, 0);
      run_xfer(32'h0, 16'd2048, 512, 32'h0, 4'hF, 1'b0);
      total++;
      if (aw_addr_q.size() !== 2 || aw_addr_q[0] !== 32'h0 || aw_len_q[0] !== 8'd255 ||
          aw_addr_q[1] !== 32'h400 || aw_len_q[1] !== 8'd255) begin
         bad++; $display("FAIL split256_aw n=%0d a0=%h l0=%0d a1=%h l1=%0d want=2/0/255/400/255",
                         aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
      foreach (w_last_q[k]) if (w_last_q[k] !== (k == 255 || k == 511)) errs++;
      total++;
      if (errs !== 0 || w_data_q.size() !== 512) begin
         bad++; $display("FAIL split256_wlast bad_positions=%0d beats=%0d want=0/512", errs, w_data_q.size());
      end
      total++;
      if (peak !== 2 || b_cnt !== 2) begin
         bad++; $display("FAIL split256_outstanding peak=%0d b=%0d want=2/2", peak, b_cnt);
      end
      total++;
      if (busy_fall_cyc !== last_b_cyc + 1) begin
         bad++; $display("FAIL split256_idle got=%0d want=%0d", busy_fall_cyc, last_b_cyc + 1);
      end
      set_knobs(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_odd_len();
      set_knobs(0, 0, 0, 0, 1, 0);
      run_xfer(32'h203, 16'd5, 2, 32'hD000_0000, 4'b0001, 1'b0);
      total++;
      if (aw_addr_q.size() !== 1 || aw_addr_q[0] !== 32'h200 || aw_len_q[0] !== 8'd1) begin
         bad++; $display("FAIL odd_aw n=%0d addr=%h len=%0d want=1/200/1", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]);
      end
      total++;
      if (w_strb_q.size() !== 2 || w_strb_q[0] !== 4'hF || w_strb_q[1] !== 4'b0001 || d_last_q[1] !== 1'b1) begin
         bad++; $display("FAIL odd_strb n=%0d s0=%h s1=%h dlast=%b want=2/f/1/1", w_strb_q.size(), w_strb_q[0], w_strb_q[1], d_last_q[1]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ea[5];
      logic [7:0]  el[5];
      int errs = 0, aw_errs = 0, nlast = 0, ndl = 0;
      ea = '{32'h804, 32'hC04, 32'h1000, 32'h1400, 32'h1800};
      el = '{8'd255, 8'd254, 8'd255, 8'd255, 8'd0};
      set_knobs(1, 1, 1, 0, 1, 0);
      run_xfer(32'h804, 16'd4096, 1024, 32'h5000_0000, 4'hF, 1'b1);
      total++;
      if (aw_addr_q.size() !== 5) begin
         bad++; $display("FAIL bp_aw_count got=%0d want=5", aw_addr_q.size());
      end else begin
         for (int k = 0; k < 5; k++) if (aw_addr_q[k] !== ea[k] || aw_len_q[k] !== el[k]) aw_errs++;
      end
      total++;
      if (aw_errs !== 0) begin bad++; $display("FAIL bp_aw_fields bad=%0d want=0", aw_errs); end
      foreach (w_data_q[k]) if (w_data_q[k] !== 32'h5000_0000 + 32'(k)) errs++;
      total++;
      if (errs !== 0 || w_data_q.size() !== 1024) begin
         bad++; $display("FAIL bp_data_order bad=%0d beats=%0d want=0/1024", errs, w_data_q.size());
      end
      foreach (w_last_q[k]) begin nlast += int'(w_last_q[k]); ndl += int'(d_last_q[k]); end
      total++;
      if (nlast !== 5 || ndl !== 1 || d_last_q[1023] !== 1'b1) begin
         bad++; $display("FAIL bp_lasts wlast=%0d dlast=%0d want=5/1", nlast, ndl);
      end
      total++;
      if (proto_err !== 0) begin bad++; $display("FAIL bp_protocol violations=%0d want=0", proto_err); end
      set_knobs(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_error_resp();
      set_knobs(0, 0, 0, 3, 1, 1);
      run_xfer(32'hFF0, 16'd32, 8, 32'hE000_0000, 4'hF, 1'b0);
      total++;
      if (aw_addr_q.size() !== 2 || aw_addr_q[1] !== 32'h1000 || aw_len_q[0] !== 8'd3 || aw_len_q[1] !== 8'd3) begin
         bad++; $display("FAIL err_aw n=%0d a1=%h l0=%0d l1=%0d want=2/1000/3/3", aw_addr_q.size(), aw_addr_q[1], aw_len_q[0], aw_len_q[1]);
      end
      total++;
      if (error !== 1'b1 || b_cnt !== 2) begin
         bad++; $display("FAIL err_set err=%b b=%0d want=1/2", error, b_cnt);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL err_sticky err=%b want=1", error); end
      @(posedge clk); #1;
      set_knobs(0, 0, 0, 0, 1, 0);
      run_xfer(32'h40, 16'd8, 2, 32'hE100_0000, 4'hF, 1'b0);
      total++;
      if (error !== 1'b0) begin bad++; $display("FAIL err_clear err=%b want=0", error); end
   endtask

   task automatic test_reset_mid();
      int n = 0, guard = 0;
      logic [9:0] ctl;
      set_knobs(0, 0, 0, 0, 1, 0);
      clear_logs();
      bus.databus_addr_i  = 32'h100;
      bus.databus_len_i   = 16'd32;
      bus.databus_valid_i = 1'b1;
      bus.databus_wstrb_i = 4'hF;
      bus.databus_wdata_i = 32'hC000_0000;
      while (n < 3 && guard < 200) begin
         @(negedge clk);
         if (bus.databus_valid_i && bus.databus_ready_o) n++;
         @(posedge clk); #1;
         guard++;
         bus.databus_wdata_i = 32'hC000_0000 + 32'(n);
      end
      total++;
      if (n !== 3) begin bad++; $display("FAIL midrst_beats got=%0d want=3", n); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ctl = {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_wlast_o, bus.databus_ready_o, bus.databus_last_o,
             bus.m_bready_o, busy, error, bus.m_awaddr_o != 32'h0, bus.m_awlen_o != 8'h0};
      total++;
      if (ctl !== 10'h000) begin bad++; $display("FAIL midrst_outputs got=%b want=0000000000", ctl); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.databus_valid_i = 1'b0;
      $display("xfer addr=%h len=%0d aborted by reset after %0d beats", 32'h100, 32, n);
      @(posedge clk); #1;
   endtask

   task automatic test_zero_len();
      int viol = 0;
      clear_logs();
      bus.databus_addr_i  = 32'h300;
      bus.databus_len_i   = 16'd0;
      bus.databus_valid_i = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.databus_ready_o || busy || bus.m_awvalid_o || bus.m_wvalid_o) viol++;
         @(posedge clk); #1;
      end
      bus.databus_valid_i = 1'b0;
      $display("xfer addr=%h len=0 ignored", 32'h300);
      total++;
      if (viol !== 0 || aw_addr_q.size() !== 0) begin
         bad++; $display("FAIL zero_len activity=%0d aw=%0d want=0/0", viol, aw_addr_q.size());
      end
      run_xfer(32'h300, 16'd4, 1, 32'hF000_0000, 4'hF, 1'b0);
      total++;
      if (aw_addr_q.size() !== 1 || aw_len_q[0] !== 8'd0 || w_last_q[0] !== 1'b1 || d_last_q[0] !== 1'b1) begin
         bad++; $display("FAIL one_beat aw=%0d len=%0d wlast=%b dlast=%b want=1/0/1/1",
                         aw_addr_q.size(), aw_len_q[0], w_last_q[0], d_last_q[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_4k_split();
      test_256_split();
      test_odd_len();
      test_backpressure();
      test_error_resp();
      test_reset_mid();
      test_zero_len();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
